// File: rtl/key_step_ctrl.sv
// rtl/key_step_ctrl.sv - pushbutton synchroniser, debouncer and step-pulse FSM for the up/down counter
// Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat stepping while a key stays pressed).
module key_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] key_n,
   output logic       enable,
   output logic       up_down,
   output logic [1:0] key_db
);

   // A zero-length debounce or repeat interval has no meaning; refuse to elaborate.
   if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("key_step_ctrl: cycle parameters must be at least 1");
   end

   // Debounce counter only ever reaches DEBOUNCE_CYCLES-1 before it is cleared.
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
   // One counter serves both the initial hold delay and the repeat period.
   localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HELD    = 2'd1,
      S_LOCKOUT = 2'd2
`ifdef AUTO_REPEAT_EN
      , S_REPEAT  = 2'd3
`endif
   } state_t;

   state_t     state_q, state_d;
   logic       enable_d;
   logic       up_down_d;
   logic [1:0] sync_a, sync_b;
   logic [1:0] key_s;
   logic       held_pressed;
   logic       other_pressed;
`ifdef AUTO_REPEAT_EN
   logic [HW-1:0] hold_q, hold_d;
`endif

   // Two-flop synchroniser per key; flops rest at 1 so a reset reads as "released".
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a <= 2'b11;
         sync_b <= 2'b11;
      end else begin
         sync_a <= key_n;
         sync_b <= sync_a;
      end
   end

   // Synchronised level in active-high form: 1 means the button is pressed.
   assign key_s = ~sync_b;

   for (genvar i = 0; i < 2; i++) begin : g_debounce
      logic [CW-1:0] cnt;
      logic          db_r;

      // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt  <= '0;
            db_r <= 1'b0;
         end else if (key_s[i] != db_r) begin
            if (cnt == DB_LAST) begin
               db_r <= key_s[i];
               cnt  <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end

      assign key_db[i] = db_r;
   end

   // up_down remembers which key started the current press: 1 -> KEY[0], 0 -> KEY[1].
   assign held_pressed  = up_down ? key_db[0] : key_db[1];
   assign other_pressed = up_down ? key_db[1] : key_db[0];

   // State register with registered step outputs, so enable is a clean one-cycle pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         enable  <= 1'b0;
         up_down <= 1'b1;
`ifdef AUTO_REPEAT_EN
         hold_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         enable  <= enable_d;
         up_down <= up_down_d;
`ifdef AUTO_REPEAT_EN
         hold_q  <= hold_d;
`endif
      end
   end

   // Press FSM: one pulse per accepted press; any two-key overlap locks out until both are released.
   always_comb begin
      state_d   = state_q;
      enable_d  = 1'b0;
      up_down_d = up_down;
`ifdef AUTO_REPEAT_EN
      hold_d    = '0;
`endif
      case (state_q)
         S_IDLE: begin
            case (key_db)
               2'b01: begin
                  enable_d  = 1'b1;
                  up_down_d = 1'b1;
                  state_d   = S_HELD;
               end
               2'b10: begin
                  enable_d  = 1'b1;
                  up_down_d = 1'b0;
                  state_d   = S_HELD;
               end
               2'b11:   state_d = S_LOCKOUT;
               default: state_d = S_IDLE;
            endcase
         end
         S_HELD: begin
            if (other_pressed) begin
               state_d = S_LOCKOUT;
            end else if (!held_pressed) begin
               state_d = S_IDLE;
            end
`ifdef AUTO_REPEAT_EN
            else if (hold_q == HOLD_LAST) begin
               enable_d = 1'b1;
               state_d  = S_REPEAT;
            end else begin
               hold_d = hold_q + HW'(1);
            end
`endif
         end
`ifdef AUTO_REPEAT_EN
         S_REPEAT: begin
            if (other_pressed) begin
               state_d = S_LOCKOUT;
            end else if (!held_pressed) begin
               state_d = S_IDLE;
            end else if (hold_q == REP_LAST) begin
               enable_d = 1'b1;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
`endif
         S_LOCKOUT: begin
            if (key_db == 2'b00) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_key_step_ctrl.sv
// tb/tb_key_step_ctrl.sv - randomized scoreboard bench for key_step_ctrl
`timescale 1ns/1ps
module tb_key_step_ctrl;

   localparam int DB   = 4;
   localparam int HOLD = 20;
   localparam int REP  = 8;
`ifdef AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] key_n;
   logic       enable;
   logic       up_down;
   logic [1:0] key_db;

   key_step_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .HOLD_CYCLES(HOLD),
      .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .key_n(key_n),
      .enable(enable),
      .up_down(up_down),
      .key_db(key_db)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pulse_count = 0;

   typedef struct {
      int c;
      bit d;
   } exp_t;
   exp_t exp_q[$];

   // Reference model: debounce as "last DB delayed samples all disagree with the accepted level",
   // press handling as the rule list, repeat timing as cycle distance from the previous pulse.
   typedef enum int {M_IDLE, M_HELD, M_LOCK, M_REP} mode_t;
   mode_t      mode = M_IDLE;
   bit         dir = 1'b1;
   logic [1:0] db_m = 2'b00;
   logic [1:0] p1 = 2'b00;
   logic [1:0] p2 = 2'b00;
   logic [1:0] seen_q[$];
   int         last_pulse = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mode       = M_IDLE;
      dir        = 1'b1;
      db_m       = 2'b00;
      p1         = 2'b00;
      p2         = 2'b00;
      last_pulse = 0;
      seen_q.delete();
      exp_q.delete();
   endtask

   always @(posedge clk) begin : model
      logic [1:0] db_old;
      logic [1:0] seen;
      bit pulse, own, oth, flip;
      cyc++;
      if (reset === 1'b1) begin
         db_old = db_m;
         pulse  = 1'b0;
         own    = dir ? db_old[0] : db_old[1];
         oth    = dir ? db_old[1] : db_old[0];
         case (mode)
            M_IDLE: begin
               if (db_old == 2'b01) begin
                  pulse = 1'b1; dir = 1'b1; mode = M_HELD;
               end else if (db_old == 2'b10) begin
                  pulse = 1'b1; dir = 1'b0; mode = M_HELD;
               end else if (db_old == 2'b11) begin
                  mode = M_LOCK;
               end
            end
            M_HELD, M_REP: begin
               if (oth) mode = M_LOCK;
               else if (!own) mode = M_IDLE;
`ifdef AUTO_REPEAT_EN
               else if (cyc - last_pulse == ((mode == M_HELD) ? HOLD : REP)) begin
                  pulse = 1'b1;
                  mode  = M_REP;
               end
`endif
            end
            M_LOCK: if (db_old == 2'b00) mode = M_IDLE;
            default: mode = M_IDLE;
         endcase
         if (pulse) begin
            last_pulse = cyc;
            exp_q.push_back('{c: cyc, d: dir});
         end
         // The debouncer at this edge sees the raw key sampled two edges earlier.
         seen = p2;
         p2   = p1;
         p1   = ~key_n;
         seen_q.push_back(seen);
         if (seen_q.size() > DB) void'(seen_q.pop_front());
         if (seen_q.size() == DB) begin
            for (int i = 0; i < 2; i++) begin
               flip = 1'b1;
               for (int k = 0; k < seen_q.size(); k++)
                  if (seen_q[k][i] == db_m[i]) flip = 1'b0;
               if (flip) db_m[i] = ~db_m[i];
            end
         end
      end
   end

   always @(negedge clk) begin : monitor
      bit   want;
      exp_t e;
      want = (exp_q.size() > 0) && (exp_q[0].c == cyc);
      if (enable === 1'b1) pulse_count++;
      if (enable !== 1'b0 || want) begin
         chk("enable_pulse", enable, want);
         if (want) begin
            e = exp_q.pop_front();
            chk("pulse_up_down", up_down, e.d);
         end
      end
      chk("key_db", key_db, db_m);
      chk("up_down_level", up_down, dir);
   end

   task automatic drive(input logic [1:0] v, input int n);
      @(posedge clk);
      #2 key_n = v;
      repeat (n - 1) @(posedge clk);
   endtask

   // Count edges after a stimulus change until enable is seen; 0 means it never came.
   task automatic wait_pulse(input string name, input int exp);
      int lat = 0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (enable === 1'b1) lat = n;
      end
      chk(name, lat, exp);
   endtask

   task automatic wait_release(input string name, input int exp);
      int lat = 0;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (key_db === 2'b00) lat = n;
      end
      chk(name, lat, exp);
   endtask

   task automatic reset_now(input string name);
      reset = 1'b0;
      model_reset();
      #1;
      chk({name, "_enable"}, enable, 1'b0);
      chk({name, "_up_down"}, up_down, 1'b1);
      chk({name, "_key_db"}, key_db, 2'b00);
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int base;
      key_n = 2'b11;
      reset = 1'b1;
      #1 reset_now("reset_initial");
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      drive(2'b11, 5);

      // KEY[0] bounce then a clean hold: one up pulse 7 clk after the last falling edge.
      base = pulse_count;
      drive(2'b10, 3);
      drive(2'b11, 1);
      @(posedge clk);
      #2 key_n = 2'b10;
      wait_pulse("bounce_latency", 7);
      drive(2'b10, 6);
      drive(2'b11, 12);
      chk("bounce_pulses", pulse_count - base, 1);

      // KEY[1] held for 60 clk: down pulse, release debounced after 6 clk.
      base = pulse_count;
      drive(2'b01, 60);
      @(posedge clk);
      #2 key_n = 2'b11;
      wait_release("release_latency", 6);
      drive(2'b11, 8);
      chk("down_hold_pulses", pulse_count - base, AUTO ? 6 : 1);
      chk("up_down_kept_low", up_down, 1'b0);

      // Both keys accepted together: no pulse; afterwards a KEY[0] press still works.
      base = pulse_count;
      drive(2'b00, 15);
      drive(2'b11, 12);
      chk("both_keys_pulses", pulse_count - base, 0);
      drive(2'b10, 12);
      drive(2'b11, 12);
      chk("after_lockout_pulses", pulse_count - base, 1);
      chk("after_lockout_dir", up_down, 1'b1);

      // Other key pressed while one is held: lockout, no extra pulse.
      base = pulse_count;
      drive(2'b10, 10);
      drive(2'b00, 10);
      drive(2'b01, 8);
      drive(2'b11, 12);
      chk("overlap_pulses", pulse_count - base, 1);

      // Long KEY[0] hold (repeat pattern when auto-repeat is built in).
      drive(2'b10, 60);
      drive(2'b11, 12);

      // Reset while KEY[0] is held, then release reset with the key still down.
      drive(2'b10, 12);
      @(posedge clk);
      #2 reset_now("reset_mid_hold");
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      wait_pulse("repress_after_reset", 7);
      drive(2'b10, 5);
      drive(2'b11, 12);

      // Random key activity with occasional resets.
      for (int s = 0; s < 200; s++) begin
         if ($urandom_range(0, 39) == 0) begin
            @(posedge clk);
            #2 reset_now("reset_random");
            repeat (2) @(posedge clk);
            #2 reset = 1'b1;
         end
         drive(2'($urandom_range(0, 3)), int'($urandom_range(1, 12)));
      end
      drive(2'b11, 30);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
